// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit for the execute stage. Runs
//            MULT, MULTU, DIV and DIVU with a fixed 34-cycle latency and
//            keeps the results in the HI/LO registers. Also services
//            MTHI/MTLO writes from busA.
// Ports    : clk    - system clock, rising edge
//            rst    - synchronous active-high reset
//            start  - begin an operation (accepted only when busy=0)
//            op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            busA   - multiplicand / dividend / MTHI-MTLO data
//            busB   - multiplier / divisor
//            mthi   - write busA into HI (idle only)
//            mtlo   - write busA into LO (idle only)
//            busy   - operation in flight
//            done   - one-cycle pulse when new HI/LO become visible
//            HI, LO - result registers
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    // Iteration count of the final CALC cycle.
    localparam logic [5:0] c_LAST_ITER = 6'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [5:0]         r_cnt;
    logic               r_is_div;
    logic               r_neg_res;   // product / quotient must be negated
    logic               r_neg_rem;   // remainder must be negated
    logic               r_div0;      // divisor was zero
    logic [WIDTH-1:0]   r_a_orig;    // unmodified dividend for divide-by-zero
    logic [WIDTH-1:0]   r_opnd;      // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] r_acc;       // mult: {hi,lo}; div: low half is dividend/quotient
    logic [WIDTH-1:0]   r_rem;       // div partial remainder
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand conditioning at start.
    logic             w_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed && busA[WIDTH-1]) ? -busA : busA;
    assign w_b_mag  = (w_signed && busB[WIDTH-1]) ? -busB : busB;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set; the carry becomes the new MSB after
    // the right shift.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};

    // Divide step: bring the next dividend bit into the partial remainder
    // and subtract the divisor if it fits. The shifted remainder needs one
    // extra bit; the difference itself always fits in WIDTH bits when kept.
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opnd;

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remv;

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_remv = r_neg_rem ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 6'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a_orig  <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg_res <= w_signed & (busA[WIDTH-1] ^ busB[WIDTH-1]);
                        r_neg_rem <= w_signed & busA[WIDTH-1];
                        r_div0    <= (busB == '0);
                        r_a_orig  <= busA;
                        r_rem     <= '0;
                        r_cnt     <= 6'd0;
                        r_busy    <= 1'b1;
                        r_state   <= c_CALC;
                        if (op[1]) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                        end
                    end else begin
                        if (mthi) begin
                            r_hi <= busA;
                        end
                        if (mtlo) begin
                            r_lo <= busA;
                        end
                    end
                end

                c_CALC: begin
                    if (r_is_div) begin
                        if (w_fits) begin
                            r_rem <= w_diff;
                            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (r_acc[0]) begin
                            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                        end else begin
                            r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
                        end
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= c_FIX;
                    end
                end

                c_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_div0) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_remv;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: directed vector table,
//            control-path sequences and randomized operations against a
//            behavioural arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .busA  (busA),
        .busB  (busB),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: plain 64-bit integer math.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    qv = q;
                    rv = r;
                    p  = {rv[31:0], qv[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else            p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Issues one operation starting in the current cycle (cycle 0) and checks
    // busy/done/HI/LO through cycle 34. Returns in cycle 34, so consecutive
    // calls issue back-to-back.
    // mode 0: quiet, 1: random bus/control noise while busy,
    // 2: second start at cycle 5 and mthi at cycle 6, 3: mthi/mtlo with start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int mode, input string tag);
        logic [31:0] hi0, lo0;
        int busy_bad, done_bad;
        hi0 = HI;
        lo0 = LO;
        busy_bad = 0;
        done_bad = 0;
        op    = o;
        busA  = a;
        busB  = b;
        start = 1'b1;
        mthi  = (mode == 3);
        mtlo  = (mode == 3);
        @(posedge clk); #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (mode == 3) begin
            chk({tag, "_mt_dropped_hi"}, HI, hi0);
            chk({tag, "_mt_dropped_lo"}, LO, lo0);
        end
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if (mode == 1) begin
                busA  = $urandom;
                busB  = $urandom;
                op    = 2'($urandom_range(0, 3));
                start = 1'($urandom_range(0, 1));
                mthi  = 1'($urandom_range(0, 1));
                mtlo  = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                if (k == 5) begin
                    start = 1'b1;
                    op    = ~o;
                    busA  = 32'hDEADBEEF;
                    busB  = 32'h00000003;
                end else if (k == 6) begin
                    start = 1'b0;
                    mthi  = 1'b1;
                    busA  = 32'h12345678;
                end else begin
                    mthi  = 1'b0;
                end
            end
            if (k == 33) begin
                start = 1'b0;
                mthi  = 1'b0;
                mtlo  = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_busy_window_errs"}, busy_bad, 0);
        chk({tag, "_early_done_errs"}, done_bad, 0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, ehi);
        chk({tag, "_lo"}, LO, elo);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] sp[6];
        sp[0] = 32'h00000000; sp[1] = 32'h00000001; sp[2] = 32'hFFFFFFFF;
        sp[3] = 32'h80000000; sp[4] = 32'h7FFFFFFF; sp[5] = 32'hFFFFFFFE;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 50));
        return $urandom;
    endfunction

    initial begin
        logic [63:0] e;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        int          done_seen, busy_seen;

        tbl[0] = '{2'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[4] = '{2'd3, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
        tbl[5] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[6] = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        tbl[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[8] = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        tbl[9] = '{2'd1, 32'd0,        32'h00012345, 32'h00000000, 32'h00000000};

        rst = 1'b1; start = 1'b0; op = 2'd0; busA = '0; busB = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        rst = 1'b0;

        // MTHI/MTLO in idle
        busA = 32'hA5A5A5A5; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", HI, 32'hA5A5A5A5);
        chk("mt_both_lo", LO, 32'hA5A5A5A5);
        chk("mt_no_done", {31'd0, done}, 32'd0);
        busA = 32'h11111111; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("mthi_hi", HI, 32'h11111111);
        chk("mthi_lo", LO, 32'hA5A5A5A5);
        busA = 32'h22222222; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo_hi", HI, 32'h11111111);
        chk("mtlo_lo", LO, 32'h22222222);

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 10; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 0,
                   $sformatf("vec%0d", i));

        // Second start at cycle 5 and mthi while busy must not disturb the result
        run_op(2'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 2, "busy_ignore");

        // start with mthi/mtlo in the same cycle: start wins (1000/7 = 142 r 6)
        run_op(2'd3, 32'd1000, 32'd7, 32'd6, 32'd142, 3, "start_vs_mt");

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = rnd_operand();
            rb = rnd_operand();
            e  = model(ro, ra, rb);
            run_op(ro, ra, rb, e[63:32], e[31:0], i % 2, $sformatf("rnd%0d_op%0d", i, ro));
        end

        // Reset in the middle of an operation
        op = 2'd1; busA = 32'd3; busB = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", done_seen, 0);
        chk("midrst_no_busy", busy_seen, 0);
        chk("midrst_hi_after", HI, 32'd0);
        chk("midrst_lo_after", LO, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the execute stage. It is fed from the same busA/busB operand buses as the ALU and runs MULT, MULTU, DIV and DIVU in a fixed 34-cycle latency. Results go into internal HI/LO registers, which the writeback path reads for MFHI/MFLO. The unit also services MTHI/MTLO writes, and its busy flag lets the pipeline stall any HI/LO consumer until the operation finishes.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  input  1  system clock; everything is updated on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin an operation; accepted only when busy=0.
- op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; latched when start is accepted.
- busA  input  32  multiplicand/dividend; also the source data for MTHI/MTLO.
- busB  input  32  multiplier/divisor.
- mthi  input  1  write busA into HI.
- mtlo  input  1  write busA into LO.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse in the first cycle new HI/LO values are visible.
- HI  output  32  high product word, or remainder.
- LO  output  32  low product word, or quotient.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On start=1: latch busA, busB and op. Signed ops convert both operands to magnitudes and record the result sign (and the remainder sign for DIV). Clear the 6-bit iteration counter, then go to CALC.
  - If start=0: mthi=1 loads HI<=busA and mtlo=1 loads LO<=busA. Both may be high in the same cycle.
- CALC: 32 iterations, one per cycle, then go to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 33-bit partial remainder.
- FIX: apply sign correction, write HI/LO, pulse done on the next cycle, return to IDLE.
- Arithmetic rules:
  - MULT/MULTU: {HI,LO} = the full 64-bit product, two's complement for MULT.
  - DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
  - Divide by zero (DIV or DIVU): HI=busA (the original dividend), LO=0xFFFFFFFF. Latency is unchanged and there is no exception.
- Boundary behaviour:
  - start while busy=1: ignored; the in-flight operation is unaffected.
  - mthi/mtlo while busy=1: ignored.
  - start and mthi/mtlo in the same IDLE cycle: start wins; the MT writes are dropped.
  - Input changes on busA/busB/op during CALC/FIX have no effect, because the operands are latched.
  - rst at any time, including mid-operation: next state IDLE, the in-flight result is discarded, and HI/LO are not updated by it.

## Timing
- Reset values: busy=0, done=0, HI=0x00000000, LO=0x00000000, state=IDLE, counter=0.
- Cycle-level sequence, with start sampled high in cycle 0:
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - busy=1 in cycles 1–33.
  - New HI/LO visible and done=1 in cycle 34, with busy=0 in that cycle.
- Back-to-back operations: a new start is accepted in cycle 34, giving one operation per 34 cycles.
- busy and done are registered outputs.
- MTHI/MTLO latency: HI/LO update one cycle after mthi/mtlo is sampled. done is not pulsed.

## Test plan
- MULT busA=7, busB=0xFFFFFFFD (-3) -> at cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, done=1 for exactly one cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, at normal latency.
- Control checks:
  - A second start with different operands at cycle 5 is ignored; the first result is intact.
  - mthi with busA=0x12345678 while busy leaves HI unchanged.
  - rst at cycle 10 -> busy=0, HI=LO=0, and no done pulse.
  - mthi and mtlo together in IDLE with busA=0xA5A5A5A5 -> HI=LO=0xA5A5A5A5 one cycle later.
